serial_adder_word_ctrl: RTL and testbench
=========================================

Name: serial_adder_word_ctrl

Overview:
Word-level sequencer for a 1-bit serial full adder.
- Accepts two WIDTH-bit operands over a valid/ready handshake.
- Shifts them LSB-first through a bit-serial adder cell, one bit per clock.
- Collects the sum bits and presents the parallel WIDTH-bit sum plus carry-out on a valid/ready output.
- Sits between parallel producers/consumers and the bit-serial arithmetic datapath.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 2..64

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  operands a/b valid
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
out_valid  output  1  sum/carry_out valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  (a + b) mod 2^WIDTH
carry_out  output  1  bit WIDTH of a + b

Behaviour:
- Reset, async on rst=1:
  - state=IDLE, carry=0, bit counter=0, shift registers=0.
  - out_valid=0, sum=0, carry_out=0, in_ready=1.
  - Takes effect immediately in any state; an in-flight operation is discarded with no output.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready at edge T: load a and b into operand shift registers, clear carry, clear counter, go to RUN.
- RUN:
  - in_ready=0; in_valid is ignored and nothing is latched.
  - Each cycle the cell adds the operand LSBs plus the carry register.
  - The sum bit shifts into the result register from the MSB side (shift right).
  - Operand registers shift right; carry register updates; counter increments.
  - The cycle with counter==WIDTH-1 is the last bit: go to DONE and latch the final carry as carry_out.
- DONE:
  - out_valid=1; sum and carry_out are held stable until out_ready=1.
  - On out_valid & out_ready: go to IDLE.
- Latency and throughput:
  - Accept at edge T; WIDTH RUN cycles; out_valid=1 from the cycle after edge T+WIDTH.
  - Throughput: one operation per WIDTH+2 cycles with out_ready held at 1.
- in_ready = (state==IDLE), combinational from state only, never from in_valid.
- sum and carry_out are forced to 0 whenever out_valid=0. This gives deterministic values for checking.
- Carry isolation: carry is cleared on every load, so no carry propagates between words.
- Arithmetic:
  - The adder cell uses only ^, &, |, ~: sum bit = a^b^c; carry = a&b | (a^b)&c.
  - No + operator anywhere in the block.
- Counter width: $clog2(WIDTH); no wrap beyond WIDTH-1.
- out_ready asserted while not in DONE has no effect.

Decomposition:
- Package serial_adder_ctrl_pkg: state enum (IDLE, RUN, DONE) as typedef state_t.
- Sub-module serial_add_bit_cell:
  - Ports: clk, rst, clr, en, a_bit, b_bit, sum_bit.
  - Internal carry flop: async reset; synchronous clr has priority over en; updates only when en=1.
  - Controller drives clr on load and en during RUN.

Test Plan:
1. WIDTH=8, a=0x35, b=0x4A accepted at edge T, out_ready=1 -> out_valid rises after edge T+8; sum=0x7F, carry_out=0; in_ready back to 1 the cycle after the handshake.
2. a=0xFF, b=0x01 -> sum=0x00, carry_out=1. Then a=0x00, b=0x00 back-to-back -> sum=0x00, carry_out=0 (carry cleared on load).
3. a=0xFF, b=0xFF with out_ready=0 for 5 cycles after out_valid -> sum=0xFE, carry_out=1 held stable all 5 cycles; in_ready=0 throughout; IDLE after out_ready=1.
4. in_valid pulsed with a=0x11, b=0x22 during RUN of a=0x01, b=0x02 -> ignored; result sum=0x03; no second out_valid.
5. rst asserted mid-RUN (after 3 bits) -> out_valid=0, sum=0, in_ready=1 immediately. A new operation a=0x80, b=0x80 -> sum=0x00, carry_out=1.
6. Random 1000 operand pairs with random in_valid/out_ready gaps -> every result matches {carry_out, sum} = a + b; the output count equals the accepted-input count.

Source files
------------

// File: rtl/serial_adder_ctrl_pkg.sv
// serial_adder_ctrl_pkg: shared state encoding for the serial adder word sequencer.
package serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_bit_cell.sv
// serial_add_bit_cell: 1-bit full adder with a registered carry, one bit per enabled clock.
module serial_add_bit_cell (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic a_bit,
    input  logic b_bit,
    output logic sum_bit,
    output logic carry
);

    logic carry_q, carry_d;

    assign sum_bit = a_bit ^ b_bit ^ carry_q;
    // clr wins over en so a fresh word never inherits the previous word's carry
    assign carry_d = clr ? 1'b0 :
                     en  ? (a_bit & b_bit) | ((a_bit ^ b_bit) & carry_q) :
                           carry_q;
    assign carry   = carry_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            carry_q <= 1'b0;
        else
            carry_q <= carry_d;
    end

endmodule

// File: rtl/serial_adder_word_ctrl.sv
// serial_adder_word_ctrl: accepts parallel operands, adds them LSB-first through a
// serial bit cell and returns the parallel sum and carry over valid/ready.
module serial_adder_word_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int CW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             load, run, last, sum_bit, carry;

    assign load = in_valid && (state_q == IDLE);
    assign run  = (state_q == RUN);
    assign last = (cnt_q == CW'(WIDTH - 1));

    // The cell's carry flop is held in DONE, so it doubles as the carry_out register
    serial_add_bit_cell u_cell (
        .clk     (clk),
        .rst     (rst),
        .clr     (load),
        .en      (run),
        .a_bit   (a_q[0]),
        .b_bit   (b_q[0]),
        .sum_bit (sum_bit),
        .carry   (carry)
    );

    always_comb begin
        state_d = load                             ? RUN  :
                  run && last                      ? DONE :
                  (state_q == DONE) && out_ready   ? IDLE : state_q;
        a_d     = load ? a  : run ? a_q >> 1 : a_q;
        b_d     = load ? b  : run ? b_q >> 1 : b_q;
        res_d   = load ? '0 : run ? {sum_bit, res_q[WIDTH-1:1]} : res_q;
        // x - (all ones) is x + 1 modulo 2^CW, keeping the block free of adders
        cnt_d   = load ? '0 : run && !last ? cnt_q - {CW{1'b1}} : cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = out_valid ? res_q : '0;
    assign carry_out = out_valid & carry;

endmodule

// File: tb/tb_serial_adder_word_ctrl.sv
// tb_serial_adder_word_ctrl: directed and randomized checks against a transaction-level model.
module tb_serial_adder_word_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         in_ready, out_valid, carry_out;
    logic [W-1:0] sum;

    int       vectors = 0, miscompares = 0;
    int       edge_cnt = 0, t_acc = 0, pops = 0, dut_outs = 0;
    bit       pending = 1'b0, exp_v;
    logic [W:0] exp_res = '0;

    serial_adder_word_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // Transaction model: one word in flight, result visible W edges after acceptance
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pending = 1'b0;
        end else begin
            edge_cnt++;
            if (pending && edge_cnt > t_acc + W && out_ready) begin
                pending = 1'b0;
                pops++;
            end else if (!pending && in_valid) begin
                pending = 1'b1;
                t_acc   = edge_cnt;
                exp_res = {1'b0, a} + {1'b0, b};
            end
        end
    end

    always @(posedge clk)
        if (!rst && out_valid && out_ready) dut_outs++;

    always @(negedge clk) begin
        if (!rst) begin
            exp_v = pending && (edge_cnt >= t_acc + W);
            chk("in_ready", in_ready, !pending);
            chk("out_valid", out_valid, exp_v);
            chk("result", {carry_out, sum}, exp_v ? exp_res : '0);
        end
    end

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input int hold,
                          input logic [W:0] lit, input string nm);
        int n;
        @(negedge clk); a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk); in_valid = 1'b0;
        chk({nm, " ready_low"}, in_ready, 0);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " latency"}, n, W);
        chk({nm, " value"}, {carry_out, sum}, lit);
        repeat (hold) begin
            @(negedge clk);
            chk({nm, " held"}, {carry_out, sum}, lit);
            chk({nm, " ready_held"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
        chk({nm, " idle"}, in_ready, 1);
        chk({nm, " cleared"}, {out_valid, carry_out, sum}, 0);
    endtask

    initial begin
        int start, cyc, outs0, n;
        repeat (2) @(negedge clk);
        chk("reset in_ready", in_ready, 1);
        chk("reset outputs", {out_valid, carry_out, sum}, 0);
        rst = 1'b0;

        run_op(8'h35, 8'h4A, 0, 9'h07F, "t1");
        run_op(8'hFF, 8'h01, 0, 9'h100, "t2a");
        run_op(8'h00, 8'h00, 0, 9'h000, "t2b");
        run_op(8'hFF, 8'hFF, 5, 9'h1FE, "t3");

        outs0 = dut_outs;
        @(negedge clk); a = 8'h01; b = 8'h02; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        repeat (3) @(negedge clk);
        a = 8'h11; b = 8'h22; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("t4 value", {carry_out, sum}, 9'h003);
        out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
        repeat (12) @(negedge clk);
        chk("t4 no second", out_valid, 0);
        chk("t4 one output", dut_outs - outs0, 1);

        @(negedge clk); a = 8'h55; b = 8'h11; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t5 rst in_ready", in_ready, 1);
        chk("t5 rst outputs", {out_valid, carry_out, sum}, 0);
        @(negedge clk); rst = 1'b0;
        run_op(8'h80, 8'h80, 0, 9'h100, "t5");

        start = pops;
        cyc   = 0;
        while (pops - start < 1000 && cyc < 40000) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 2) != 0);
            a         = W'($urandom);
            b         = W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cyc++;
        end
        chk("random ops completed", (pops - start >= 1000), 1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (20) @(negedge clk);
        chk("output count", dut_outs, pops);
        chk("drained", pending, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
